// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder stage: one full-adder cell is reused LSB-first across WIDTH
// clocks, with operands and result exchanged over valid/ready handshakes.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Combinational 1-bit full-adder cell; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [1:0]       fa_s;
    logic [WIDTH-1:0] sum_next_s;
    logic             in_ready_s;

    // Full-adder cell evaluation and the next sum-register value.
    always_comb begin
        fa_s       = full_add(a_sr_r[0], b_sr_r[0], carry_r);
        sum_next_s = {fa_s[0], sum_sr_r[WIDTH-1:1]};
    end

    // Accept readiness: IDLE always, DONE only when the result leaves the same edge.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                DONE:    in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign busy      = busy_r;

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            sum_sr_r    <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            result_r    <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    sum_sr_r <= sum_next_s;
                    carry_r  <= fa_s[1];
                    if (cnt_r == CNT_LAST) begin
                        result_r    <= sum_next_s;
                        cout_r      <= fa_s[1];
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    // Result stays frozen until the downstream takes it.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            a_sr_r  <= a;
                            b_sr_r  <= b;
                            carry_r <= cin;
                            cnt_r   <= '0;
                            busy_r  <= 1'b1;
                            state_r <= SHIFT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
